// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone classic arbiter.
// Master 0 is the core (fetch/load/store), master 1 the debug/loader port.
// Round-robin on ties, grant held for the whole cyc, and a watchdog that aborts
// a cycle the slave never acknowledges so the core cannot hang.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i
);

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StGnt0  = 4'b0010,
        StGnt1  = 4'b0100,
        StAbort = 4'b1000
    } state_e;

    // A zero limit turns the watchdog off; the wrapped limit value is then never used.
    localparam bit              WdEn    = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] ToLimit = TO_W'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic            last_q, last_d;      // index of the most recently granted master
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            gnt_cyc;
    logic            stall;

    // State, round-robin pointer and watchdog counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;             // m0 wins the first tie
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Bus steering: the granted master is copied straight through; idle/abort drive nothing.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        unique case (state_q)
            StGnt0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i & m0_stb_i;
            end
            StGnt1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i & m1_stb_i;
            end
            // last_q still names the master whose cycle timed out.
            StAbort: begin
                m0_err_o = ~last_q;
                m1_err_o = last_q;
            end
            default: ;
        endcase
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
    end

    // Arbitration, release and watchdog next-state logic.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        to_cnt_d = to_cnt_q;
        gnt_cyc  = (state_q == StGnt0) ? m0_cyc_i : m1_cyc_i;
        stall    = s_stb_o & ~s_ack_i;
        unique case (state_q)
            StIdle: begin
                to_cnt_d = '0;
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = StGnt0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = StGnt1;
                    last_d  = 1'b1;
                end
            end
            StGnt0, StGnt1: begin
                if (!gnt_cyc) begin
                    // Release or legal abandon: the slave simply sees cyc fall.
                    state_d  = StIdle;
                    to_cnt_d = '0;
                end else if (WdEn && stall) begin
                    if (to_cnt_q == ToLimit) begin
                        state_d  = StAbort;
                        to_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end else if (s_ack_i) begin
                    to_cnt_d = '0;
                end
            end
            StAbort: begin
                state_d  = StIdle;
                to_cnt_d = '0;
            end
            default: begin
                state_d  = StIdle;
                to_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed arbitration/watchdog/reset scenarios plus random
// two-master traffic. Each issued transfer pushes its expected outcome into a
// per-master queue; a negedge monitor pops and checks on every ack or err.
module tb_wb_arbiter2;

    localparam int TO = 4;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        err;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_cyc   [2];
    logic        m_stb   [2];
    logic        m_we    [2];
    logic [3:0]  m_sel   [2];
    logic [31:0] m_adr   [2];
    logic [31:0] m_wdat  [2];
    logic        m_ack   [2];
    logic        m_err   [2];
    logic [31:0] m_rdat  [2];
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat, s_rdat;

    int    n_checks = 0;
    int    n_err    = 0;
    xfer_t exp0[$];
    xfer_t exp1[$];
    int    ack_order[$];

    // Slave model controls
    int force_lat = -1;   // >= 0: fixed wait states, else random 0..2
    bit mute      = 1'b0; // never acknowledge
    bit ack_force = 1'b0; // raw ack regardless of bus state
    int wait_cnt  = 0;
    int cur_lat   = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(
        .TIMEOUT_CYCLES(TO),
        .TO_W          (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m0_cyc_i(m_cyc[0]),
        .m0_stb_i(m_stb[0]),
        .m0_we_i (m_we[0]),
        .m0_sel_i(m_sel[0]),
        .m0_adr_i(m_adr[0]),
        .m0_dat_i(m_wdat[0]),
        .m0_ack_o(m_ack[0]),
        .m0_err_o(m_err[0]),
        .m0_dat_o(m_rdat[0]),
        .m1_cyc_i(m_cyc[1]),
        .m1_stb_i(m_stb[1]),
        .m1_we_i (m_we[1]),
        .m1_sel_i(m_sel[1]),
        .m1_adr_i(m_adr[1]),
        .m1_dat_i(m_wdat[1]),
        .m1_ack_o(m_ack[1]),
        .m1_err_o(m_err[1]),
        .m1_dat_o(m_rdat[1]),
        .s_cyc_o (s_cyc),
        .s_stb_o (s_stb),
        .s_we_o  (s_we),
        .s_sel_o (s_sel),
        .s_adr_o (s_adr),
        .s_dat_o (s_wdat),
        .s_ack_i (s_ack),
        .s_dat_i (s_rdat)
    );

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        if (a == 32'h4000_0000) return 32'h0000_0013;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b, required %0b", nm, act, exp);
        end
    endtask

    // Slave: acknowledges after cur_lat wait states of an active strobe.
    assign s_rdat = rd_data(s_adr);
    assign s_ack  = ack_force | (s_cyc & s_stb & ~mute & (wait_cnt == cur_lat));

    always @(posedge clk) begin
        if (reset || !(s_cyc && s_stb) || s_ack) begin
            wait_cnt <= 0;
            cur_lat  <= (force_lat >= 0) ? force_lat : int'($urandom_range(0, 2));
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Monitor: every ack/err must match the oldest outstanding transfer of that master.
    always @(negedge clk) begin : mon
        xfer_t x;
        bit    have;
        if (!reset) begin
            for (int m = 0; m < 2; m++) begin
                if (m_ack[m] || m_err[m]) begin
                    have = 1'b0;
                    if (m == 0 && exp0.size() > 0) begin x = exp0.pop_front(); have = 1'b1; end
                    if (m == 1 && exp1.size() > 0) begin x = exp1.pop_front(); have = 1'b1; end
                    if (!have) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL m%0d unexpected response: ack=%0b err=%0b, required none",
                                 m, m_ack[m], m_err[m]);
                    end else begin
                        ack_order.push_back(m);
                        chk1($sformatf("m%0d err vs ack", m), m_err[m], x.err);
                        chk1($sformatf("m%0d other ack low", m), m_ack[1-m], 1'b0);
                        if (x.err) begin
                            chk1($sformatf("m%0d s_cyc low on err", m), s_cyc, 1'b0);
                        end else begin
                            chk($sformatf("m%0d s_adr", m), s_adr, x.adr);
                            chk1($sformatf("m%0d s_we", m), s_we, x.we);
                            chk($sformatf("m%0d s_sel", m), 32'(s_sel), 32'(x.sel));
                            if (x.we) chk($sformatf("m%0d s_dat_o", m), s_wdat, x.dat);
                            else      chk($sformatf("m%0d rdata", m), m_rdat[m], rd_data(x.adr));
                        end
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One master cycle of n strobes; called and returns just after a rising edge.
    task automatic burst(input int m, input int n, input logic we, input logic [3:0] sel,
                         input logic [31:0] adr0, input logic [31:0] dat0,
                         input logic [31:0] stride);
        xfer_t x;
        bit    got;
        bit    was_err;
        for (int i = 0; i < n; i++) begin
            x.we  = we;
            x.sel = sel;
            x.adr = adr0 + stride * 32'(i);
            x.dat = dat0 + stride * 32'(i);
            x.err = mute || (force_lat >= TO);
            if (m == 0) exp0.push_back(x);
            else        exp1.push_back(x);
            m_cyc[m]  = 1'b1;
            m_stb[m]  = 1'b1;
            m_we[m]   = x.we;
            m_sel[m]  = x.sel;
            m_adr[m]  = x.adr;
            m_wdat[m] = x.dat;
            got     = 1'b0;
            was_err = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk);
                if (m_ack[m] || m_err[m]) begin
                    got     = 1'b1;
                    was_err = m_err[m];
                end
            end
            chk1($sformatf("m%0d response within budget", m), got, 1'b1);
            @(posedge clk);
            #1;
            if (was_err || !got) break;
        end
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    task automatic tie_pair();
        fork
            burst(0, 1, 1'b0, 4'hF, 32'h5000_0000, 32'h0, 32'h4);
            burst(1, 1, 1'b1, 4'hC, 32'h6000_0010, 32'h1234_5678, 32'h4);
        join
    endtask

    task automatic expect_order2(input string nm, input int a, input int b);
        chk({nm, " count"}, 32'(ack_order.size()), 32'd2);
        if (ack_order.size() == 2) begin
            chk({nm, " first"}, 32'(ack_order[0]), 32'(a));
            chk({nm, " second"}, 32'(ack_order[1]), 32'(b));
        end
        ack_order.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        reset = 1'b1;
        for (int m = 0; m < 2; m++) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
            m_sel[m] = '0;   m_adr[m] = '0;   m_wdat[m] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Tie on the first cycle after reset: m0 first, one dead idle cycle, then m1.
        force_lat = 0;
        fork
            tie_pair();
            begin
                @(negedge clk);
                chk1("reset s_cyc", s_cyc, 1'b0);
                chk1("reset m0_ack", m_ack[0], 1'b0);
                chk1("reset m1_ack", m_ack[1], 1'b0);
                chk1("reset m0_err", m_err[0], 1'b0);
                chk1("reset m1_err", m_err[1], 1'b0);
                @(negedge clk);
                chk1("tie m0 acked first", m_ack[0], 1'b1);
                chk1("tie m1 waits", m_ack[1], 1'b0);
                @(negedge clk);
                chk1("tie release s_cyc", s_cyc, 1'b0);
                @(negedge clk);
                chk1("tie dead idle s_cyc", s_cyc, 1'b0);
                @(negedge clk);
                chk1("tie m1 granted s_cyc", s_cyc, 1'b1);
                chk1("tie m1 ack", m_ack[1], 1'b1);
            end
        join
        expect_order2("tie1", 0, 1);

        // m0 alone, then a tie: alternation hands the tie to m1.
        cycles(2);
        burst(0, 1, 1'b0, 4'hF, 32'h5000_0100, 32'h0, 32'h4);
        ack_order.delete();
        cycles(2);
        tie_pair();
        expect_order2("tie2", 1, 0);

        // Single m0 read with two wait states.
        cycles(2);
        force_lat = 2;
        fork
            burst(0, 1, 1'b0, 4'hF, 32'h4000_0000, 32'h0, 32'h4);
            begin
                @(negedge clk);
                chk1("t1 idle before grant", s_cyc, 1'b0);
                @(negedge clk);
                chk1("t1 s_cyc one cycle later", s_cyc, 1'b1);
                chk("t1 s_adr", s_adr, 32'h4000_0000);
                @(negedge clk);
                chk1("t1 no early ack", m_ack[0], 1'b0);
                @(negedge clk);
                chk1("t1 m0_ack", m_ack[0], 1'b1);
                chk("t1 m0_dat", m_rdat[0], 32'h0000_0013);
                chk1("t1 m1_ack", m_ack[1], 1'b0);
            end
        join
        ack_order.delete();

        // m1 holds cyc over three stores while m0 is requesting.
        cycles(2);
        force_lat = -1;
        fork
            burst(1, 3, 1'b1, 4'b0011, 32'h8000_0002, 32'h0000_BEEF, 32'h0);
            begin
                @(posedge clk);
                #1;
                burst(0, 1, 1'b0, 4'hF, 32'h1000_0000, 32'h0, 32'h4);
            end
        join
        chk("t3 count", 32'(ack_order.size()), 32'd4);
        if (ack_order.size() == 4) begin
            for (int i = 0; i < 3; i++) chk($sformatf("t3 hold %0d", i), 32'(ack_order[i]), 32'd1);
            chk("t3 m0 after", 32'(ack_order[3]), 32'd0);
        end
        ack_order.delete();

        // Slave never acks an m0 fetch: err after TO grant cycles, then m1 is served.
        cycles(2);
        mute = 1'b1;
        fork
            burst(0, 1, 1'b0, 4'hF, 32'h2000_0000, 32'h0, 32'h4);
            begin
                @(negedge clk);
                chk1("t4 idle", s_cyc, 1'b0);
                for (int i = 0; i < TO; i++) begin
                    @(negedge clk);
                    chk1($sformatf("t4 waiting s_cyc %0d", i), s_cyc, 1'b1);
                    chk1($sformatf("t4 no early err %0d", i), m_err[0], 1'b0);
                end
                @(negedge clk);
                chk1("t4 m0_err pulse", m_err[0], 1'b1);
                chk1("t4 abort s_cyc", s_cyc, 1'b0);
                chk1("t4 m1_err", m_err[1], 1'b0);
                @(negedge clk);
                chk1("t4 err one cycle", m_err[0], 1'b0);
            end
        join
        mute = 1'b0;
        burst(1, 1, 1'b0, 4'hF, 32'h2000_0100, 32'h0, 32'h4);
        expect_order2("t4", 0, 1);

        // Ack lands on the watchdog limit cycle: normal completion.
        cycles(2);
        force_lat = TO - 1;
        fork
            burst(0, 1, 1'b0, 4'hF, 32'h2000_0040, 32'h0, 32'h4);
            begin
                @(negedge clk);
                for (int i = 0; i < TO - 1; i++) begin
                    @(negedge clk);
                    chk1($sformatf("t6 no early ack %0d", i), m_ack[0], 1'b0);
                end
                @(negedge clk);
                chk1("t6 ack at limit", m_ack[0], 1'b1);
                chk1("t6 no err at limit", m_err[0], 1'b0);
                @(negedge clk);
                chk1("t6 no err after", m_err[0], 1'b0);
            end
        join
        force_lat = -1;
        ack_order.delete();

        // Reset during a pending m1 strobe.
        cycles(2);
        mute = 1'b1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
        m_sel[1] = 4'hF; m_adr[1] = 32'h3000_0000;
        @(negedge clk);
        @(negedge clk);
        chk1("t5 granted", s_cyc, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mute = 1'b0;
        ack_force = 1'b1;
        @(negedge clk);
        chk1("t5 s_cyc after reset", s_cyc, 1'b0);
        chk1("t5 m1_ack blocked", m_ack[1], 1'b0);
        chk1("t5 m0_ack blocked", m_ack[0], 1'b0);
        @(posedge clk);
        #1;
        ack_force = 1'b0;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        cycles(2);
        ack_order.delete();
        tie_pair();
        expect_order2("t5 tie", 0, 1);

        // Random concurrent traffic from both masters.
        cycles(2);
        fork
            for (int k = 0; k < 20; k++) begin
                int g0;
                g0 = int'($urandom_range(0, 3));
                if (g0 > 0) cycles(g0);
                burst(0, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 4'($urandom),
                      $urandom & 32'hFFFF_FFFC, $urandom, 32'h4);
            end
            for (int k = 0; k < 20; k++) begin
                int g1;
                g1 = int'($urandom_range(0, 3));
                if (g1 > 0) cycles(g1);
                burst(1, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 4'($urandom),
                      $urandom & 32'hFFFF_FFFC, $urandom, 32'h4);
            end
        join
        g = 3;
        cycles(g);
        chk("m0 queue drained", 32'(exp0.size()), 32'd0);
        chk("m1 queue drained", 32'(exp1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
